// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the locking round-robin arbiter.
// Grant state enum plus a one-hot to binary index converter.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int OH_MAX_W = 64;

    // Index of the set bit in a one-hot vector; an all-zero vector yields 0.
    function automatic logic [31:0] onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
        logic [31:0] idx;
        idx = 32'd0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority pick: first set request at or after ptr,
// wrapping modulo NUM_REQ, via a double-width masked lowest-bit isolate.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               win_vld_o,
    output logic [NUM_REQ-1:0] win_onehot_o,
    output logic [IDX_W-1:0]   win_idx_o
);

    localparam int DW = 2 * NUM_REQ;

    logic [DW-1:0] dbl_s;
    logic [DW-1:0] mask_s;
    logic [DW-1:0] cand_s;
    logic [DW-1:0] iso_s;

    // The upper copy is never masked, so requests below ptr are seen after the wrap.
    always_comb begin
        dbl_s  = {req_i, req_i};
        mask_s = {DW{1'b0}};
        for (int i = 0; i < DW; i++) begin
            mask_s[i] = (i >= int'(ptr_i));
        end
        cand_s = dbl_s & mask_s;
        iso_s  = cand_s & (~cand_s + DW'(1));
    end

    assign win_vld_o    = |cand_s;
    assign win_onehot_o = iso_s[NUM_REQ-1:0] | iso_s[DW-1:NUM_REQ];
    assign win_idx_o    = IDX_W'(onehot_to_idx(OH_MAX_W'(win_onehot_o)));

endmodule

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter with per-packet grant lock, optional burst limit and
// zero-bubble hand-off between consecutive winners.
module rr_arbiter_lock
    import rr_arb_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter bit  LOCK_EN   = 1'b1,
    parameter int  MAX_BURST = 0,
    parameter int  BURST_W   = 8,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_last,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [BURST_W-1:0] beat_cnt
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BURST_W-1:0] beat_q, beat_d;

    logic               busy_s;
    logic               cur_req_s;
    logic               cur_last_s;
    logic               xfer_s;
    logic               rel_last_s;
    logic               rel_abort_s;
    logic               rel_burst_s;
    logic               release_s;
    logic [BURST_W:0]   beat_inc_s;
    logic [IDX_W-1:0]   ptr_rel_s;
    logic [IDX_W-1:0]   pick_ptr_s;
    logic [NUM_REQ-1:0] pick_req_s;
    logic               win_vld_s;
    logic [NUM_REQ-1:0] win_oh_s;
    logic [IDX_W-1:0]   win_idx_s;

    // Release conditions and the request/pointer fed to the picker.
    always_comb begin
        busy_s      = (state_q == BUSY);
        cur_req_s   = req[gnt_idx_q];
        cur_last_s  = req_last[gnt_idx_q];
        xfer_s      = gnt_valid_q & out_ready & cur_req_s;
        rel_last_s  = xfer_s & (cur_last_s | (LOCK_EN == 1'b0));
        rel_abort_s = busy_s & ~cur_req_s;
        beat_inc_s  = {1'b0, beat_q} + {{BURST_W{1'b0}}, 1'b1};
        rel_burst_s = (MAX_BURST != 0) & xfer_s & (beat_inc_s == (BURST_W+1)'(MAX_BURST));
        release_s   = busy_s & (rel_last_s | rel_abort_s | rel_burst_s);
        // Explicit wrap so non power-of-two NUM_REQ never relies on overflow.
        ptr_rel_s   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : gnt_idx_q + IDX_W'(1);
        pick_ptr_s  = busy_s ? ptr_rel_s : ptr_q;
        pick_req_s  = rel_abort_s ? (req & ~gnt_q) : req;
    end

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i        (pick_req_s),
        .ptr_i        (pick_ptr_s),
        .win_vld_o    (win_vld_s),
        .win_onehot_o (win_oh_s),
        .win_idx_o    (win_idx_s)
    );

    // Next-state for grant, pointer and beat counter.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        case (state_q)
            IDLE: begin
                if (win_vld_s) begin
                    state_d     = BUSY;
                    gnt_d       = win_oh_s;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = win_idx_s;
                    beat_d      = {BURST_W{1'b0}};
                end else begin
                    gnt_d       = {NUM_REQ{1'b0}};
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = {IDX_W{1'b0}};
                end
            end
            BUSY: begin
                if (release_s) begin
                    ptr_d  = ptr_rel_s;
                    beat_d = {BURST_W{1'b0}};
                    if (win_vld_s) begin
                        state_d     = BUSY;
                        gnt_d       = win_oh_s;
                        gnt_valid_d = 1'b1;
                        gnt_idx_d   = win_idx_s;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = {NUM_REQ{1'b0}};
                        gnt_valid_d = 1'b0;
                        gnt_idx_d   = {IDX_W{1'b0}};
                    end
                end else if (xfer_s && (beat_q != {BURST_W{1'b1}})) begin
                    beat_d = beat_inc_s[BURST_W-1:0];
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = {NUM_REQ{1'b0}};
                gnt_valid_d = 1'b0;
                gnt_idx_d   = {IDX_W{1'b0}};
                beat_d      = {BURST_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= {NUM_REQ{1'b0}};
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= {IDX_W{1'b0}};
            ptr_q       <= {IDX_W{1'b0}};
            beat_q      <= {BURST_W{1'b0}};
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed bench for rr_arbiter_lock: three configurations (4-way locked,
// 4-way with a 2-beat burst limit, 5-way) driven from one sequence.
module tb_rr_arbiter_lock;

    logic clk;
    logic rst;

    logic [3:0] req4, last4, gnt4;
    logic       rdy4, vld4;
    logic [1:0] idx4;
    logic [7:0] beat4;

    logic [3:0] reqb, lastb, gntb;
    logic       rdyb, vldb;
    logic [1:0] idxb;
    logic [7:0] beatb;

    logic [4:0] req5, last5, gnt5;
    logic       rdy5, vld5;
    logic [2:0] idx5;
    logic [7:0] beat5;

    int passed = 0;
    int total  = 0;

    rr_arbiter_lock #(.NUM_REQ(4), .LOCK_EN(1'b1), .MAX_BURST(0), .BURST_W(8)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .req_last(last4), .out_ready(rdy4),
        .gnt(gnt4), .gnt_valid(vld4), .gnt_idx(idx4), .beat_cnt(beat4)
    );

    rr_arbiter_lock #(.NUM_REQ(4), .LOCK_EN(1'b1), .MAX_BURST(2), .BURST_W(8)) dutb (
        .clk(clk), .rst(rst), .req(reqb), .req_last(lastb), .out_ready(rdyb),
        .gnt(gntb), .gnt_valid(vldb), .gnt_idx(idxb), .beat_cnt(beatb)
    );

    rr_arbiter_lock #(.NUM_REQ(5), .LOCK_EN(1'b1), .MAX_BURST(0), .BURST_W(8)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .req_last(last5), .out_ready(rdy5),
        .gnt(gnt5), .gnt_valid(vld5), .gnt_idx(idx5), .beat_cnt(beat5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst  = 1'b1;
        req4 = 4'b0000; last4 = 4'b0000; rdy4 = 1'b0;
        reqb = 4'b0000; lastb = 4'b0000; rdyb = 1'b0;
        req5 = 5'b00000; last5 = 5'b00000; rdy5 = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt4), 32'h0);
        chk("rst_vld", 32'(vld4), 32'h0);
        chk("rst_idx", 32'(idx4), 32'h0);
        chk("rst_beat", 32'(beat4), 32'h0);
        req4 = 4'b0100;
        tick();
        chk("rst_req_held", 32'(gnt4), 32'h0);

        // Reset release and 1-cycle latency
        rst = 1'b0;
        tick();
        chk("lat_gnt", 32'(gnt4), 32'h4);
        chk("lat_idx", 32'(idx4), 32'h2);
        chk("lat_vld", 32'(vld4), 32'h1);
        req4 = 4'b0000;
        tick();
        chk("drop_gnt", 32'(gnt4), 32'h0);
        chk("drop_vld", 32'(vld4), 32'h0);

        // Fairness from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req4 = 4'b1111; last4 = 4'b1111; rdy4 = 1'b1;
        tick();
        chk("fair0", 32'(gnt4), 32'h1);
        tick();
        chk("fair1", 32'(gnt4), 32'h2);
        tick();
        chk("fair2", 32'(gnt4), 32'h4);
        chk("fair2_idx", 32'(idx4), 32'h2);
        tick();
        chk("fair3", 32'(gnt4), 32'h8);
        tick();
        chk("fair4", 32'(gnt4), 32'h1);
        req4 = 4'b0000; last4 = 4'b0000;
        tick();
        chk("fair_idle", 32'(gnt4), 32'h0);

        // Packet lock with out_ready 1,0,1,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req4 = 4'b0011; last4 = 4'b0000; rdy4 = 1'b0;
        tick();
        chk("lock_gnt0", 32'(gnt4), 32'h1);
        chk("lock_beat0", 32'(beat4), 32'h0);
        rdy4 = 1'b1;
        tick();
        chk("lock_b1_gnt", 32'(gnt4), 32'h1);
        chk("lock_b1_cnt", 32'(beat4), 32'h1);
        rdy4 = 1'b0;
        req4 = 4'b0001;
        tick();
        chk("lock_stall_gnt", 32'(gnt4), 32'h1);
        chk("lock_stall_cnt", 32'(beat4), 32'h1);
        rdy4 = 1'b1;
        req4 = 4'b0011;
        tick();
        chk("lock_b2_gnt", 32'(gnt4), 32'h1);
        chk("lock_b2_cnt", 32'(beat4), 32'h2);
        last4 = 4'b0001;
        tick();
        chk("lock_handoff", 32'(gnt4), 32'h2);
        chk("lock_handoff_cnt", 32'(beat4), 32'h0);
        req4 = 4'b0000; last4 = 4'b0000;
        tick();
        chk("lock_idle", 32'(gnt4), 32'h0);

        // Long burst on requester 2, then reset mid-burst
        req4 = 4'b0100; rdy4 = 1'b1;
        tick();
        chk("burst_gnt", 32'(gnt4), 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("burst_cnt5", 32'(beat4), 32'h5);
        chk("burst_gnt_held", 32'(gnt4), 32'h4);
        rst = 1'b1;
        tick();
        chk("midrst_gnt", 32'(gnt4), 32'h0);
        chk("midrst_beat", 32'(beat4), 32'h0);
        chk("midrst_vld", 32'(vld4), 32'h0);
        rst = 1'b0;
        req4 = 4'b1111;
        tick();
        chk("postrst_gnt", 32'(gnt4), 32'h1);
        req4 = 4'b0000; rdy4 = 1'b0;
        tick();

        // Burst limit of 2 beats
        reqb = 4'b0110; lastb = 4'b0000; rdyb = 1'b1;
        tick();
        chk("maxb_g1", 32'(gntb), 32'h2);
        tick();
        chk("maxb_g1_b1", 32'(gntb), 32'h2);
        chk("maxb_cnt1", 32'(beatb), 32'h1);
        tick();
        chk("maxb_g2", 32'(gntb), 32'h4);
        chk("maxb_cnt0", 32'(beatb), 32'h0);
        tick();
        chk("maxb_g2_b1", 32'(gntb), 32'h4);
        tick();
        chk("maxb_back", 32'(gntb), 32'h2);
        reqb = 4'b0000;
        tick();

        // 5-way abort with pointer wrap
        req5 = 5'b10000; rdy5 = 1'b0;
        tick();
        chk("w5_gnt4", 32'(gnt5), 32'h10);
        chk("w5_idx4", 32'(idx5), 32'h4);
        req5 = 5'b00011;
        tick();
        chk("w5_wrap_gnt", 32'(gnt5), 32'h1);
        chk("w5_wrap_idx", 32'(idx5), 32'h0);
        req5 = 5'b00000;
        tick();
        chk("w5_idle_gnt", 32'(gnt5), 32'h0);
        chk("w5_idle_vld", 32'(vld5), 32'h0);
        chk("w5_idle_idx", 32'(idx5), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
